mix_columns_iter: RTL and testbench

- Iterative AES MixColumns stage; sits directly downstream of the byte substitution/ShiftRows path in the round datapath and consumes the 128-bit state they produce.
- Processes COLS_PER_CYCLE columns per clock over a shared GF(2^8) multiply datapath.
- Uses a valid/ready handshake on both sides.
- Optionally supports InvMixColumns for the decrypt round.

---
 rtl/mix_columns_iter.sv | 157 +++++++++++++++
 tb/tb_mix_columns_iter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns stage.
// Transforms COLS_PER_CYCLE columns (1, 2 or 4) per clock over a shared
// GF(2^8) datapath, with valid/ready handshakes on input and output.
// Optional macro INV_MIX_EN compiles in the InvMixColumns datapath, which is
// selected by the inverse input latched at the accept edge.
// Byte k sits at state[8k:8k+7] (bit 8k = MSB); column c = bytes 4c..4c+3.
`timescale 1ns/1ps

module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  input  logic [0:127] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] state_out,
  output logic         busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm;
  logic [0:127] work;
  logic [0:127] next_work;
  logic [1:0]   cnt;
  logic         inv_q;
  logic         last;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward column: rows of the circulant matrix {02,03,01,01}.
  function automatic logic [31:0] fwd_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3, d0, d1, d2, d3;
    a0 = col[31:24]; a1 = col[23:16]; a2 = col[15:8]; a3 = col[7:0];
    d0 = xtime(a0);  d1 = xtime(a1);  d2 = xtime(a2);  d3 = xtime(a3);
    return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
            a0 ^ d1 ^ d2 ^ a2 ^ a3,
            a0 ^ a1 ^ d2 ^ d3 ^ a3,
            d0 ^ a0 ^ a1 ^ a2 ^ d3};
  endfunction

`ifdef INV_MIX_EN
  // Inverse column: rows of the circulant matrix {0e,0b,0d,09}.
  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`else
  // Forward-only build: the inverse input and its latch have no consumer.
  logic unused_inverse;
  assign unused_inverse = inverse ^ inv_q;
`endif

  assign last = (3'(cnt) + 3'(COLS_PER_CYCLE)) == 3'd4;

  // Transform the current group of columns in place; other columns pass through.
  always_comb begin
    // NOTE: next_work is fully assigned before the loop so no latch is inferred.
    next_work = work;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
`ifdef INV_MIX_EN
      next_work[32*(int'(cnt)+j) +: 32] = inv_q ? inv_col(work[32*(int'(cnt)+j) +: 32])
                                                : fwd_col(work[32*(int'(cnt)+j) +: 32]);
`else
      next_work[32*(int'(cnt)+j) +: 32] = fwd_col(work[32*(int'(cnt)+j) +: 32]);
`endif
    end
  end

  // Working state register: loaded on accept, updated in place while running.
  always_ff @(posedge clk) begin
    // NOTE: work is not reset; it is always loaded on accept before it is read.
    if (fsm == IDLE && in_valid) begin
      work <= state_in;
    end else if (fsm == RUN) begin
      work <= next_work;
    end
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments.
    if (!reset_n) begin
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      state_out <= '0;
      cnt       <= '0;
      inv_q     <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
`ifdef INV_MIX_EN
            inv_q <= inverse;
`else
            inv_q <= 1'b0;
`endif
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            fsm      <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 2'(COLS_PER_CYCLE);
          if (last) begin
            state_out <= next_work;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Testbench for mix_columns_iter: three instances (1, 2 and 4 columns per
// cycle) share the stimulus; directed vectors plus a GF(2^8) reference model.
`timescale 1ns/1ps

module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         inverse;
  logic [0:127] state_in;
  logic         out_ready;

  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         busy_a      [3];
  logic [0:127] state_out_a [3];

  int           lat_a [3];
  logic [0:127] res_a [3];

  int total = 0;
  int bad   = 0;

  localparam logic [0:127] V_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [0:127] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [0:127] V_SW_IN   = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [0:127] V_SW_OUT  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
  localparam logic [0:127] V_B_IN    = 128'hd4bf5d30_d4d4d4d5_2d26314c_01010101;
  localparam logic [0:127] V_B_OUT   = 128'h046681e5_d5d5d7d6_4d7ebdf8_01010101;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .inverse(inverse), .state_in(state_in), .out_valid(out_valid_a[0]),
    .out_ready(out_ready), .state_out(state_out_a[0]), .busy(busy_a[0]));

  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .inverse(inverse), .state_in(state_in), .out_valid(out_valid_a[1]),
    .out_ready(out_ready), .state_out(state_out_a[1]), .busy(busy_a[1]));

  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a[2]),
    .inverse(inverse), .state_in(state_in), .out_valid(out_valid_a[2]),
    .out_ready(out_ready), .state_out(state_out_a[2]), .busy(busy_a[2]));

  // Generic shift-and-add GF(2^8) multiply, modulus x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [0:127] mix_model(input logic [0:127] s, input bit inv);
    logic [7:0] coef [4];
    logic [0:127] r = '0;
    logic [7:0] acc;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - row + 4) % 4], s[32*c + 8*k +: 8]);
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Present one state with out_ready=1 and record each instance's latency/result.
  task automatic run_one(input logic [0:127] s, input logic inv);
    bit seen [3];
    for (int d = 0; d < 3; d++) begin
      seen[d] = 1'b0; lat_a[d] = 0; res_a[d] = '0;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inverse   = inv;
    state_in  = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    inverse  = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && out_valid_a[d]) begin
          seen[d]  = 1'b1;
          lat_a[d] = cyc;
          res_a[d] = state_out_a[d];
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    inverse   = 1'b0;
    out_ready = 1'b1;
    state_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (in_ready_a[d] !== 1'b1) begin
        bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready_a[d]);
      end
      total++;
      if (out_valid_a[d] !== 1'b0) begin
        bad++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid_a[d]);
      end
      total++;
      if (busy_a[d] !== 1'b0) begin
        bad++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy_a[d]);
      end
      total++;
      if (state_out_a[d] !== 128'h0) begin
        bad++; $display("FAIL reset_state_out[%0d]: got %h want 0", d, state_out_a[d]);
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    run_one(V_FWD_IN, 1'b0);
    total++;
    if (lat_a[0] !== 4) begin
      bad++; $display("FAIL fwd_latency: got %0d want 4", lat_a[0]);
    end
    total++;
    if (res_a[0] !== V_FWD_OUT) begin
      bad++; $display("FAIL fwd_result: got %h want %h", res_a[0], V_FWD_OUT);
    end
  endtask

  task automatic test_inverse();
    logic [0:127] exp;
`ifdef INV_MIX_EN
    exp = V_FWD_IN;
`else
    exp = mix_model(V_FWD_OUT, 1'b0);
`endif
    run_one(V_FWD_OUT, 1'b1);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (res_a[d] !== exp) begin
        bad++; $display("FAIL inv_result[%0d]: got %h want %h", d, res_a[d], exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state_in  = V_FWD_IN;
    @(posedge clk); #1;
    state_in = V_B_IN;  // second request held pending during the whole transfer
    lat = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (out_valid_a[0]) begin lat = cyc; break; end
    end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (state_out_a[0] !== V_FWD_OUT) begin
        bad++; $display("FAIL bp_hold_data cyc %0d: got %h want %h", i, state_out_a[0], V_FWD_OUT);
      end
      total++;
      if (in_ready_a[0] !== 1'b0 || out_valid_a[0] !== 1'b1) begin
        bad++; $display("FAIL bp_hold_ctrl cyc %0d: got ready=%b valid=%b want ready=0 valid=1",
                        i, in_ready_a[0], out_valid_a[0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1) begin
      bad++; $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1",
                      out_valid_a[0], in_ready_a[0]);
    end
    total++;
    if (state_out_a[0] !== V_FWD_OUT) begin
      bad++; $display("FAIL bp_keep_out: got %h want %h", state_out_a[0], V_FWD_OUT);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
      bad++; $display("FAIL bp_second_accept: got ready=%b busy=%b want ready=0 busy=1",
                      in_ready_a[0], busy_a[0]);
    end
    lat = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (out_valid_a[0]) begin lat = cyc; break; end
    end
    total++;
    if (lat !== 4 || state_out_a[0] !== V_B_OUT) begin
      bad++; $display("FAIL bp_second_result: got lat=%0d %h want lat=4 %h", lat, state_out_a[0], V_B_OUT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = V_SW_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl: got ready=%b valid=%b busy=%b want 1 0 0",
                      in_ready_a[0], out_valid_a[0], busy_a[0]);
    end
    total++;
    if (state_out_a[0] !== 128'h0) begin
      bad++; $display("FAIL midrst_state_out: got %h want 0", state_out_a[0]);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid_a[0] !== 1'b0) begin
        bad++; $display("FAIL midrst_stale cyc %0d: got valid=%b want 0", i, out_valid_a[0]);
      end
    end
  endtask

  task automatic test_sweep();
    run_one(V_SW_IN, 1'b0);
    total++;
    if (lat_a[1] !== 2) begin
      bad++; $display("FAIL sweep_latency_2: got %0d want 2", lat_a[1]);
    end
    total++;
    if (lat_a[2] !== 1) begin
      bad++; $display("FAIL sweep_latency_4: got %0d want 1", lat_a[2]);
    end
    for (int d = 0; d < 3; d++) begin
      total++;
      if (res_a[d] !== V_SW_OUT) begin
        bad++; $display("FAIL sweep_result[%0d]: got %h want %h", d, res_a[d], V_SW_OUT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] st [8];
    int in_idx  = 0;
    int out_idx = 0;
    bit acc;
    for (int i = 0; i < 8; i++)
      st[i] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    inverse   = 1'b0;
    in_valid  = 1'b1;
    state_in  = st[0];
    acc = in_ready_a[0];
    for (int cyc = 0; cyc < 200 && out_idx < 8; cyc++) begin
      @(posedge clk); #1;
      if (acc) begin
        in_idx++;
        if (in_idx < 8) state_in = st[in_idx];
        else in_valid = 1'b0;
      end
      if (out_valid_a[0]) begin
        total++;
        if (state_out_a[0] !== mix_model(st[out_idx], 1'b0)) begin
          bad++; $display("FAIL b2b_result[%0d]: got %h want %h", out_idx, state_out_a[0],
                          mix_model(st[out_idx], 1'b0));
        end
        out_idx++;
      end
      acc = in_valid && in_ready_a[0];
    end
    in_valid = 1'b0;
    total++;
    if (out_idx !== 8) begin
      bad++; $display("FAIL b2b_count: got %0d outputs want 8", out_idx);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_reset_mid_run();
    test_sweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
